rr_grant_arbiter: RTL and testbench

//   Round-robin arbiter that shares one downstream resource among N requesters.
//   - Grants are registered and held while the owner keeps requesting, up to a

---
 rtl/rr_grant_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, encoded index and a
// per-owner burst limit. A released owner drops to lowest priority.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;

    logic           release_now;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] scan_start;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_onehot;

    // Release decision and the pointer that takes effect if the owner lets go.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        release_now = 1'b0;
        ptr_next    = ptr;
        if (state == GRANT) begin
            release_now = !req[gnt_id] ||
                          ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));
            ptr_next    = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
        scan_start = (state == GRANT) ? ptr_next : ptr;
    end

    // Rotating-priority encode: walking the scan order backwards lets the
    // earliest requester (closest to scan_start) overwrite the others.
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(scan_start) + i) % N]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(scan_start) + i) % N);
            end
        end
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of all the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        ptr      <= ptr_next;
                        hold_cnt <= '0;
                        if (win_found) begin
                            gnt       <= win_onehot;
                            gnt_id    <= win_id;
                            gnt_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output invariants; a grant must always point at a live request.
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid:  assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
    a_index:  assert property (@(posedge clk) disable iff (rst)
                               gnt_valid |-> (gnt == win_onehot_of(gnt_id)));

    function automatic logic [N-1:0] win_onehot_of(input logic [IDW-1:0] id);
        logic [N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench: three arbiters (burst limits 16, 4, unlimited) share
// stimulus and are compared every cycle against an owner/run-length model.
module tb_rr_grant_arbiter;

    localparam int N = 8;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt_o [NI];
    logic [2:0]   id_o  [NI];
    logic         val_o [NI];

    int lims [NI] = '{16, 4, 0};
    int m_owner [NI];
    int m_ptr   [NI];
    int m_run   [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) dut_h16 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(val_o[0]));
    rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4)) dut_h4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(val_o[1]));
    rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(0)) dut_h0 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_o[2]), .gnt_id(id_o[2]), .gnt_valid(val_o[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    // Owner -1 means idle; run counts cycles the current owner has held.
    task automatic model_edge(input logic [N-1:0] r, input logic rs);
        for (int m = 0; m < NI; m++) begin
            if (rs) begin
                m_owner[m] = -1;
                m_ptr[m]   = 0;
                m_run[m]   = 0;
            end else if (m_owner[m] < 0) begin
                m_owner[m] = first_from(r, m_ptr[m]);
                m_run[m]   = 1;
            end else if (!r[m_owner[m]] || (lims[m] > 0 && m_run[m] == lims[m])) begin
                m_ptr[m]   = (m_owner[m] + 1) % N;
                m_owner[m] = first_from(r, m_ptr[m]);
                m_run[m]   = 1;
            end else begin
                m_run[m]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < NI; m++) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_owner[m] >= 0) eg[m_owner[m]] = 1'b1;
            check($sformatf("h%0d_gnt", lims[m]), 32'(gnt_o[m]), 32'(eg));
            check($sformatf("h%0d_id", lims[m]), 32'(id_o[m]),
                  (m_owner[m] >= 0) ? m_owner[m] : 0);
            check($sformatf("h%0d_valid", lims[m]), 32'(val_o[m]), 32'(m_owner[m] >= 0));
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         rs;

        // Reset and idle
        do_reset();
        for (int m = 0; m < NI; m++) check("reset_gnt", 32'(gnt_o[m]), 32'h0);
        for (int c = 0; c < 20; c++) begin
            step(8'h00, 1'b0);
            check("idle_valid", 32'(val_o[0]), 32'h0);
        end

        // Basic latency and back-to-back handoff
        step(8'h05, 1'b0);
        check("basic_gnt0", 32'(gnt_o[0]), 32'h01);
        check("basic_id0", 32'(id_o[0]), 32'h0);
        step(8'h04, 1'b0);
        check("basic_gnt2", 32'(gnt_o[0]), 32'h04);
        check("basic_id2", 32'(id_o[0]), 32'h2);
        step(8'h05, 1'b0);
        check("basic_hold2", 32'(gnt_o[0]), 32'h04);

        // Fairness with burst limit 4: owners rotate every four cycles
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(8'hFF, 1'b0);
            check("fair_owner", 32'(id_o[1]), 32'((c / 4) % 8));
            check("fair_valid", 32'(val_o[1]), 32'h1);
        end

        // Pointer wrap from owner 7 back to 0
        do_reset();
        step(8'h40, 1'b0);
        check("wrap_own6", 32'(gnt_o[0]), 32'h40);
        step(8'h81, 1'b0);
        check("wrap_own7", 32'(gnt_o[0]), 32'h80);
        step(8'h01, 1'b0);
        check("wrap_own0", 32'(gnt_o[0]), 32'h01);

        // Reset mid-grant
        do_reset();
        step(8'h10, 1'b0);
        check("rstmid_pre", 32'(gnt_o[0]), 32'h10);
        step(8'h10, 1'b1);
        check("rstmid_gnt", 32'(gnt_o[0]), 32'h00);
        check("rstmid_valid", 32'(val_o[0]), 32'h0);
        step(8'h30, 1'b0);
        check("rstmid_regnt", 32'(gnt_o[0]), 32'h10);
        check("rstmid_id", 32'(id_o[0]), 32'h4);

        // Unlimited hold keeps the owner as long as it requests
        do_reset();
        for (int c = 0; c < 100; c++) begin
            step(8'h28, 1'b0);
            check("unlim_hold", 32'(gnt_o[2]), 32'h08);
        end
        step(8'h20, 1'b0);
        check("unlim_next", 32'(gnt_o[2]), 32'h20);

        // Randomized traffic
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: r = r;
                1: r = 8'($urandom);
                2: r = r ^ (8'h01 << $urandom_range(0, 7));
                default: r = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
            endcase
            rs = ($urandom_range(0, 99) == 0);
            step(r, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
